// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-stage responder: FSM states,
// request encodings, register-window offsets and the address decoder.
package cpu_mem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Decoded target of a captured request
  typedef enum logic [2:0] {
    SEL_RAM  = 3'd0,
    SEL_PWM  = 3'd1,
    SEL_TMR  = 3'd2,
    SEL_TCLR = 3'd3,
    SEL_BAD  = 3'd4
  } sel_t;

  // cpu_rw encodings: bit[1] valid, bit[0] read
  localparam logic [1:0] REQ_RD = 2'b11;
  localparam logic [1:0] REQ_WR = 2'b10;

  // Byte offsets inside the register window
  localparam logic [31:0] PWM_OFS  = 32'h0000_0000;
  localparam logic [31:0] TMR_OFS  = 32'h0000_0004;
  localparam logic [31:0] TCLR_OFS = 32'h0000_0008;

  // Map a byte address to its target; the two low address bits never matter.
  function automatic sel_t decode_addr(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] ram_words);
    logic [31:0] word_addr;
    word_addr = addr & 32'hFFFF_FFFC;
    if ((word_addr >> 2) < ram_words) begin
      return SEL_RAM;
    end else if (word_addr == base + PWM_OFS) begin
      return SEL_PWM;
    end else if (word_addr == base + TMR_OFS) begin
      return SEL_TMR;
    end else if (word_addr == base + TCLR_OFS) begin
      return SEL_TCLR;
    end
    return SEL_BAD;
  endfunction

endpackage

// File: rtl/cpu_rw_ram.sv
// Single-port 32-bit data RAM with write enable and registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module cpu_rw_ram
  import cpu_mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Write port and read-first registered read on the same address
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_rw_responder.sv
// Target-side responder for the CPU memory-stage port. Captures a request,
// waits WAIT_STATES cycles, then returns a one-cycle completion strobe with
// read data driven on the shared data bus. Targets are a local data RAM and
// the PWM/timer register window; anything else is flagged with addr_err.
module cpu_rw_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
  parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_rw_addr,
  input  logic [1:0]  cpu_rw,
  inout  wire  [31:0] cpu_rw_data,
  output logic        cpu_rw_vld,
  output logic [31:0] pwm_data,
  output logic [31:0] timer_data,
  output logic        timer_clr,
  output logic        addr_err
);

  localparam int unsigned AW       = $clog2(RAM_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // FSM and wait counter
  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_capture;
  logic        w_to_resp;
  logic        w_vld;
  logic        w_drive;

  // Captured request
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_op_rd;

  // Response-side registers
  sel_t        r_sel;
  logic [31:0] r_rdata_mmio;
  logic [31:0] r_pwm;
  logic [31:0] r_timer;

  // The request being serviced: straight from the port while idle (so a
  // zero-wait request can complete on its capture edge), else the capture.
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic        w_cur_rd;
  sel_t        w_cur_sel;

  logic        w_ram_we;
  logic [31:0] w_ram_q;
  logic [31:0] w_rdata;
  logic [31:0] w_bus_in;

  assign w_bus_in    = cpu_rw_data;
  assign w_cur_addr  = (r_state == IDLE) ? cpu_rw_addr : r_addr;
  assign w_cur_rd    = (r_state == IDLE) ? cpu_rw[0]   : r_op_rd;
  assign w_cur_wdata = (r_state == IDLE) ? w_bus_in    : r_wdata;
  assign w_cur_sel   = decode_addr(w_cur_addr, MMIO_BASE, 32'(RAM_WORDS));

  // RAM writes only on the edge entering RESP; gating with rst_n keeps a
  // reset-abandoned transaction from committing.
  assign w_ram_we = w_to_resp && !w_cur_rd && (w_cur_sel == SEL_RAM) && rst_n;

  cpu_rw_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_cur_addr[AW+1:2]),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_ram_q)
  );

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic, capture/commit strobes and completion outputs
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_to_resp    = 1'b0;
    w_vld        = 1'b0;
    w_drive      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_rw[1]) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_next = RESP;
            w_to_resp    = 1'b1;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_vld        = 1'b1;
        w_drive      = r_op_rd;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request capture; inputs are ignored once the request is held here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_op_rd <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= cpu_rw_addr;
      r_op_rd <= cpu_rw[0];
      if (!cpu_rw[0]) begin
        r_wdata <= w_bus_in;
      end
    end
  end

  // Register decode result and non-RAM read data on the edge entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= SEL_RAM;
      r_rdata_mmio <= 32'd0;
    end else if (w_to_resp) begin
      r_sel <= w_cur_sel;
      case (w_cur_sel)
        SEL_PWM:  r_rdata_mmio <= r_pwm;
        SEL_TMR:  r_rdata_mmio <= r_timer;
        SEL_BAD:  r_rdata_mmio <= BAD_DATA;
        default:  r_rdata_mmio <= 32'd0;
      endcase
    end
  end

  // PWM and timer register writes, committed on the edge entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm   <= 32'd0;
      r_timer <= 32'd0;
    end else if (w_to_resp && !w_cur_rd) begin
      if (w_cur_sel == SEL_PWM) begin
        r_pwm <= w_cur_wdata;
      end
      if (w_cur_sel == SEL_TMR) begin
        r_timer <= w_cur_wdata;
      end
    end
  end

  assign w_rdata     = (r_sel == SEL_RAM) ? w_ram_q : r_rdata_mmio;
  assign cpu_rw_data = w_drive ? w_rdata : 'z;

  assign cpu_rw_vld  = w_vld;
  assign timer_clr   = w_vld && !r_op_rd && (r_sel == SEL_TCLR);
  assign addr_err    = w_vld && (r_sel == SEL_BAD);
  assign pwm_data    = r_pwm;
  assign timer_data  = r_timer;

endmodule

// File: tb/tb_cpu_rw_responder.sv
// Bench for cpu_rw_responder: directed scenarios followed by randomized
// traffic, checked against a behavioural memory/register model.
module tb_cpu_rw_responder;

  localparam int unsigned WS       = 1;
  localparam int unsigned RW       = 1024;
  localparam logic [31:0] MB       = 32'h0001_0000;
  localparam logic [31:0] BAD      = 32'hDEAD_BEEF;
  localparam logic [31:0] IDLE_PAT = 32'h0BAD_F00D;

  typedef enum {K_RAM, K_PWM, K_TMR, K_TCLR, K_BAD} kind_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [1:0]  rw;
  logic [31:0] tb_bus;
  logic        tb_drv;
  wire  [31:0] cpu_rw_data;
  logic        vld;
  logic [31:0] pwm;
  logic [31:0] tmr;
  logic        tclr;
  logic        aerr;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [RW];
  bit          m_known [RW];
  logic [31:0] m_pwm;
  logic [31:0] m_tmr;
  bit          at_resp;

  assign cpu_rw_data = tb_drv ? tb_bus : 'z;

  always #5 clk = ~clk;

  cpu_rw_responder #(
    .WAIT_STATES (WS),
    .RAM_WORDS   (RW),
    .MMIO_BASE   (MB),
    .BAD_DATA    (BAD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_rw_addr (addr),
    .cpu_rw      (rw),
    .cpu_rw_data (cpu_rw_data),
    .cpu_rw_vld  (vld),
    .pwm_data    (pwm),
    .timer_data  (tmr),
    .timer_clr   (tclr),
    .addr_err    (aerr)
  );

  function automatic kind_t kind_of(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w / 4 < RW)  return K_RAM;
    if (w == MB)     return K_PWM;
    if (w == MB + 4) return K_TMR;
    if (w == MB + 8) return K_TCLR;
    return K_BAD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles with the request deasserted and the bus parked on a pattern
  task automatic idle(input int n);
    rw = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tb_drv = 1'b1;
      tb_bus = IDLE_PAT;
      @(negedge clk);
      chk("idle_vld", vld, 0);
      chk("idle_tclr", tclr, 0);
      chk("idle_aerr", aerr, 0);
      chk("idle_bus", cpu_rw_data, IDLE_PAT);
    end
    at_resp = 1'b0;
  endtask

  // One transaction; called at a negedge, returns at the negedge of its RESP cycle
  task automatic txn(input bit rd, input logic [31:0] a, input logic [31:0] d, input bit hold);
    kind_t       k;
    int          idx;
    bit          rd_known;
    logic [31:0] exp_rd;
    logic [31:0] old_pwm;
    logic [31:0] old_tmr;
    bit          last;
    k        = kind_of(a);
    idx      = int'((a >> 2) % RW);
    rd_known = 1'b1;
    rw       = {1'b1, rd};
    addr     = a;
    if (at_resp) begin
      @(posedge clk);
      #1;
      tb_drv = !rd;
      tb_bus = rd ? IDLE_PAT : d;
      @(negedge clk);
      chk("gap_vld", vld, 0);
      if (!rd) chk("gap_bus", cpu_rw_data, d);
    end else begin
      tb_drv = !rd;
      tb_bus = rd ? IDLE_PAT : d;
    end
    @(posedge clk);
    old_pwm = m_pwm;
    old_tmr = m_tmr;
    case (k)
      K_RAM:  begin exp_rd = m_ram[idx]; rd_known = m_known[idx]; end
      K_PWM:  exp_rd = m_pwm;
      K_TMR:  exp_rd = m_tmr;
      K_TCLR: exp_rd = 32'd0;
      default: exp_rd = BAD;
    endcase
    if (!rd) begin
      case (k)
        K_RAM:  begin m_ram[idx] = d; m_known[idx] = 1'b1; end
        K_PWM:  m_pwm = d;
        K_TMR:  m_tmr = d;
        default: ;
      endcase
    end
    for (int c = 1; c <= WS + 1; c++) begin
      @(negedge clk);
      last = (c == WS + 1);
      chk("vld", vld, last);
      chk("timer_clr", tclr, last && !rd && (k == K_TCLR));
      chk("addr_err", aerr, last && (k == K_BAD));
      if (last) begin
        chk("pwm", pwm, m_pwm);
        chk("timer", tmr, m_tmr);
      end else begin
        chk("pwm_early", pwm, old_pwm);
        chk("timer_early", tmr, old_tmr);
      end
      if (!rd) chk("wr_bus", cpu_rw_data, d);
      else if (last && rd_known) chk("rd_data", cpu_rw_data, exp_rd);
      $display("txn %s addr=%h c=%0d vld=%0b bus=%h", rd ? "RD" : "WR", a, c, vld, cpu_rw_data);
      if (c == 1 && !hold) begin
        rw   = 2'b00;
        addr = $urandom;
      end
    end
    at_resp = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    logic [31:0] lo;
    sel = $urandom_range(0, 9);
    lo  = 32'($urandom_range(0, 3));
    if (sel <= 3) return 32'($urandom_range(0, 15)) * 4 + lo;
    if (sel == 4) return 32'($urandom_range(RW - 4, RW - 1)) * 4 + lo;
    if (sel == 5) return MB + lo;
    if (sel == 6) return MB + 4 + lo;
    if (sel == 7) return MB + 8 + lo;
    if (sel == 8) return (MB + 12) + 32'($urandom_range(0, 2)) * (32'h0001_0000) + lo;
    return RW * 4 + 32'($urandom_range(0, 7)) * 4;
  endfunction

  initial begin
    rst_n   = 1'b0;
    rw      = 2'b00;
    addr    = 32'd0;
    tb_bus  = IDLE_PAT;
    tb_drv  = 1'b1;
    at_resp = 1'b0;
    m_pwm   = 32'd0;
    m_tmr   = 32'd0;
    for (int i = 0; i < int'(RW); i++) m_known[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_tclr", tclr, 0);
    chk("rst_aerr", aerr, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_timer", tmr, 0);
    chk("rst_bus", cpu_rw_data, IDLE_PAT);
    rst_n = 1'b1;
    idle(2);

    // RAM write then read-back
    txn(1'b0, 32'h10, 32'h1234_5678, 1'b0);
    txn(1'b1, 32'h10, 32'h0, 1'b0);
    idle(1);

    // PWM / timer registers
    txn(1'b0, MB,     32'h0000_00FF, 1'b0);
    txn(1'b0, MB + 4, 32'h0000_1000, 1'b0);
    txn(1'b1, MB,     32'h0, 1'b0);
    txn(1'b1, MB + 4, 32'h0, 1'b0);

    // Timer clear pulse and its read value
    txn(1'b0, MB + 8, 32'hCAFE_0001, 1'b0);
    txn(1'b1, MB + 8, 32'h0, 1'b0);

    // Unmapped access: BAD_DATA, addr_err, no side effects
    txn(1'b1, 32'h0002_0000, 32'h0, 1'b0);
    txn(1'b0, 32'h0002_0000, 32'h7777_7777, 1'b0);
    txn(1'b1, MB,     32'h0, 1'b0);
    txn(1'b1, 32'h10, 32'h0, 1'b0);
    idle(1);

    // Back-to-back writes with the request held continuously
    txn(1'b0, 32'h0, 32'h1111_0000, 1'b1);
    txn(1'b0, 32'h4, 32'h2222_0004, 1'b1);
    txn(1'b0, 32'h8, 32'h3333_0008, 1'b1);
    idle(1);
    txn(1'b1, 32'h0, 32'h0, 1'b1);
    txn(1'b1, 32'h4, 32'h0, 1'b1);
    txn(1'b1, 32'h8, 32'h0, 1'b1);
    idle(1);

    // Reset during WAIT abandons an in-flight write
    txn(1'b0, 32'h20, 32'h5555_5555, 1'b0);
    txn(1'b0, MB, 32'h0000_0077, 1'b0);
    idle(1);
    rw     = REQ_WR_TB();
    addr   = 32'h20;
    tb_bus = 32'hAAAA_AAAA;
    tb_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_vld", vld, 0);
    rst_n = 1'b0;
    rw    = 2'b00;
    #1;
    chk("abort_pwm_async", pwm, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_hold_vld", vld, 0);
      chk("abort_hold_pwm", pwm, 0);
      chk("abort_hold_timer", tmr, 0);
    end
    m_pwm  = 32'd0;
    m_tmr  = 32'd0;
    tb_bus = IDLE_PAT;
    rst_n  = 1'b1;
    idle(2);
    txn(1'b1, 32'h20, 32'h0, 1'b0);
    chk("abort_ram_kept", cpu_rw_data, 32'h5555_5555);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] REQ_WR_TB();
    return 2'b10;
  endfunction

endmodule
